// File: rtl/switch_pkg.sv
// Shared types and defaults for the board switch conditioning path.
package switch_pkg;

    typedef enum logic {STABLE, COUNT} db_state_t;

    localparam int DEFAULT_DEBOUNCE = 4;
    localparam int N_SW_DEFAULT     = 9;

endpackage

// File: rtl/debounce_cell.sv
// One switch bit: two-flop synchroniser followed by a STABLE/COUNT debounce FSM.
module debounce_cell
    import switch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
    input  logic clk,
    input  logic n_reset,
    input  logic sw_raw,
    output logic sw_db,
    output logic sw_changed,
    output logic changed_next
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1, sync2;
    db_state_t        state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             db_nx;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            state      <= STABLE;
            cnt        <= '0;
            sw_db      <= 1'b0;
            sw_changed <= 1'b0;
        end else begin
            sync1      <= sw_raw;
            sync2      <= sync1;
            state      <= state_nx;
            cnt        <= cnt_nx;
            sw_db      <= db_nx;
            sw_changed <= changed_next;
        end
    end

    // changed_next is exported so the top can register any_change in step with sw_changed
    always_comb begin
        state_nx     = state;
        cnt_nx       = '0;
        db_nx        = sw_db;
        changed_next = 1'b0;
        case (state)
            STABLE: begin
                if (sync2 != sw_db) begin
                    state_nx = COUNT;
                    cnt_nx   = CNT_W'(1);
                end
            end
            COUNT: begin
                if (sync2 == sw_db) begin
                    state_nx = STABLE;
                end else if (cnt == CNT_LAST) begin
                    db_nx        = sync2;
                    changed_next = 1'b1;
                    state_nx     = STABLE;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: state_nx = STABLE;
        endcase
    end

endmodule

// File: rtl/switch_conditioner.sv
// Conditions the raw board data switches into clean levels and change strobes for the cpu.
module switch_conditioner
    import switch_pkg::*;
#(
    parameter int N_SW            = N_SW_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw_db,
    output logic [N_SW-1:0] sw_changed,
    output logic            any_change
);

    logic [N_SW-1:0] changed_nx;

    for (genvar i = 0; i < N_SW; i++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clk         (clk),
            .n_reset     (n_reset),
            .sw_raw      (sw_raw[i]),
            .sw_db       (sw_db[i]),
            .sw_changed  (sw_changed[i]),
            .changed_next(changed_nx[i])
        );
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            any_change <= 1'b0;
        end else begin
            any_change <= |changed_nx;
        end
    end

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench for switch_conditioner with DEBOUNCE_CYCLES=4.
module tb_switch_conditioner;

    logic       clk = 1'b0;
    logic       n_reset;
    logic [8:0] sw_raw;
    logic [8:0] sw_db;
    logic [8:0] sw_changed;
    logic       any_change;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    switch_conditioner #(
        .N_SW           (9),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .sw_raw    (sw_raw),
        .sw_db     (sw_db),
        .sw_changed(sw_changed),
        .any_change(any_change)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called at a negedge: applies raw, expects old level for 5 edges, new level and strobe on the 6th.
    task automatic expect_change(input string tag, input logic [8:0] raw,
                                 input logic [8:0] old_db, input logic [8:0] new_db,
                                 input logic [8:0] mask);
        sw_raw = raw;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk({tag, " hold"}, 32'(sw_db), 32'(old_db));
            chk({tag, " quiet"}, 32'({any_change, sw_changed}), 32'd0);
        end
        @(negedge clk);
        chk({tag, " db"}, 32'(sw_db), 32'(new_db));
        chk({tag, " strobe"}, 32'(sw_changed), 32'(mask));
        chk({tag, " any"}, 32'(any_change), 32'd1);
        @(negedge clk);
        chk({tag, " db after"}, 32'(sw_db), 32'(new_db));
        chk({tag, " strobe end"}, 32'({any_change, sw_changed}), 32'd0);
    endtask

    initial begin
        n_reset = 1'b1;
        sw_raw  = 9'h1FF;
        #3 n_reset = 1'b0;
        #1;
        chk("reset db", 32'(sw_db), 32'd0);
        chk("reset strobe", 32'(sw_changed), 32'd0);
        chk("reset any", 32'(any_change), 32'd0);
        @(negedge clk);
        n_reset = 1'b1;
        expect_change("reset release", 9'h1FF, 9'h000, 9'h1FF, 9'h1FF);

        expect_change("all low", 9'h000, 9'h1FF, 9'h000, 9'h1FF);
        expect_change("data 4", 9'h004, 9'h000, 9'h004, 9'h004);
        expect_change("data 28", 9'h01C, 9'h004, 9'h01C, 9'h018);
        expect_change("data 0", 9'h000, 9'h01C, 9'h000, 9'h01C);

        // 3-period glitch on the branch switch is rejected
        sw_raw = 9'h100;
        repeat (3) @(negedge clk);
        sw_raw = 9'h000;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("glitch3 db", 32'(sw_db), 32'd0);
            chk("glitch3 quiet", 32'({any_change, sw_changed}), 32'd0);
        end

        // 4-period pulse is accepted, then debounced back low
        sw_raw = 9'h100;
        repeat (4) @(negedge clk);
        sw_raw = 9'h000;
        @(negedge clk);
        chk("pulse4 pre", 32'(sw_db), 32'd0);
        @(negedge clk);
        chk("pulse4 db", 32'(sw_db), 32'h100);
        chk("pulse4 strobe", 32'(sw_changed), 32'h100);
        chk("pulse4 any", 32'(any_change), 32'd1);
        @(negedge clk);
        chk("pulse4 strobe end", 32'({any_change, sw_changed}), 32'd0);
        repeat (2) @(negedge clk);
        chk("pulse4 still high", 32'(sw_db), 32'h100);
        @(negedge clk);
        chk("pulse4 fall db", 32'(sw_db), 32'd0);
        chk("pulse4 fall strobe", 32'(sw_changed), 32'h100);
        @(negedge clk);

        // bounce 1,0,1,0 then hold 1 on bit 0
        for (int k = 0; k < 4; k++) begin
            sw_raw = (k % 2 == 0) ? 9'h001 : 9'h000;
            @(negedge clk);
            chk("bounce db", 32'(sw_db), 32'd0);
            chk("bounce quiet", 32'({any_change, sw_changed}), 32'd0);
        end
        expect_change("bounce hold", 9'h001, 9'h000, 9'h001, 9'h001);
        expect_change("bounce clear", 9'h000, 9'h001, 9'h000, 9'h001);

        // reset in the middle of a count on bit 3
        sw_raw = 9'h008;
        repeat (3) @(negedge clk);
        n_reset = 1'b0;
        #1;
        chk("midreset db", 32'(sw_db), 32'd0);
        chk("midreset quiet", 32'({any_change, sw_changed}), 32'd0);
        @(negedge clk);
        chk("midreset held", 32'(sw_db), 32'd0);
        n_reset = 1'b1;
        expect_change("midreset release", 9'h008, 9'h000, 9'h008, 9'h008);
        expect_change("midreset clear", 9'h000, 9'h008, 9'h000, 9'h008);

        expect_change("simultaneous", 9'h1FF, 9'h000, 9'h1FF, 9'h1FF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/switch_conditioner.md
Name: switch_conditioner

Overview:
- Input-conditioning stage directly upstream of the cpu.
- Takes the raw board data switches SW[8:0] and passes each through a two-flop synchroniser and a per-bit debounce state machine.
- Drives clean, glitch-free switch values onto the cpu SW[8:0] inputs, plus one-cycle change strobes.
- SW[8] is the branch-condition switch; SW[7:0] is the data input. Reset (SW[9]) does not pass through this block.

Parameters:
- N_SW, 9, number of conditioned switch bits.
- DEBOUNCE_CYCLES, 4, consecutive mismatching samples needed to accept a new level. Legal range 2..255.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width. Derived; never overridden.

Ports:
- clk  input  1  system clock.
- n_reset  input  1  asynchronous, active-low reset.
- sw_raw  input  N_SW  raw asynchronous switch levels.
- sw_db  output  N_SW  debounced switch levels; feeds cpu SW[8:0].
- sw_changed  output  N_SW  per-bit one-cycle pulse, high in the cycle sw_db[i] takes a new value.
- any_change  output  1  OR-reduction of sw_changed (registered, same cycle).

Behaviour:
- Reset: asynchronous on n_reset low. Sync flops, sw_db, sw_changed, any_change, every counter = 0; every cell goes to STABLE. Reset is released synchronously to clk by the system.
- Synchroniser: sync1 <= sw_raw; sync2 <= sync1. Only sync2 is used downstream.
- Per-bit FSM, states STABLE and COUNT:
  - STABLE, sync2 == sw_db: stay; cnt = 0.
  - STABLE, sync2 != sw_db: go to COUNT; cnt = 1.
  - COUNT, sync2 != sw_db, cnt < DEBOUNCE_CYCLES-1: cnt++.
  - COUNT, sync2 != sw_db, cnt == DEBOUNCE_CYCLES-1: sw_db <= sync2; sw_changed[i] <= 1; go to STABLE; cnt = 0.
  - COUNT, sync2 == sw_db (bounce back): go to STABLE; cnt = 0; no strobe.
- Latency:
  - A raw level set before rising edge E0 and held appears on sw_db after edge E0+DEBOUNCE_CYCLES+1, i.e. the (DEBOUNCE_CYCLES+2)th edge.
  - sw_changed is high for exactly that one cycle.
- Glitch rejection: a raw pulse whose synchronised width is below DEBOUNCE_CYCLES samples never changes sw_db and never strobes. A width of exactly DEBOUNCE_CYCLES samples is accepted.
- Bits are fully independent. Simultaneous changes on several bits strobe together; any_change is a single pulse.
- Counter never exceeds DEBOUNCE_CYCLES-1, so no wrap is possible.
- Reset mid-count: the partial count is discarded. A switch held high through reset release is re-debounced and appears after DEBOUNCE_CYCLES+2 edges.
- All outputs are registered; there are no combinational paths from sw_raw.

Decomposition:
- Package switch_pkg holds:
  - typedef enum logic {STABLE, COUNT} db_state_t;
  - localparam DEFAULT_DEBOUNCE = 4;
  - localparam N_SW_DEFAULT = 9.
- Sub-module debounce_cell: one bit, holding its synchroniser, FSM, counter, sw_db bit and strobe bit.
  - Parameterised by DEBOUNCE_CYCLES.
  - Instantiated N_SW times in a generate loop.
- The top level adds only the any_change register.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: pulse n_reset low with sw_raw=9'h1FF → sw_db=0, sw_changed=0, any_change=0 immediately. After release, sw_db=9'h1FF on the 6th edge, with one-cycle sw_changed=9'h1FF and any_change=1.
- Clean data change: sw_raw[7:0] 0→4 held → sw_db[7:0]=4 after exactly 6 edges, sw_changed=9'h004 for one cycle. Then 4→28 → sw_db=28, sw_changed=9'h018 (bits flipped) for one cycle.
- Glitch: sw_raw[8] high for 3 clock periods then low → sw_db[8] stays 0, no sw_changed or any_change pulse. Repeat with 4 periods → sw_db[8] goes 1, then back to 0 after the return debounce.
- Bounce: sw_raw[0] toggles 1,0,1,0 each cycle, then holds 1 → sw_db[0] rises only 6 edges after the final hold begins; exactly one strobe.
- Reset mid-count: raise sw_raw[3], assert n_reset after 3 edges, release, keep sw_raw[3]=1 → sw_db[3]=0 through reset, then 1 on the 6th edge after release.
- Simultaneous: sw_raw 0→9'h1FF in one cycle → all bits update on the same edge, any_change high for exactly one cycle.
